// File: rtl/syscall_unit_pkg.sv
// Shared definitions for the SYSCALL service unit: service codes, the FSM
// state encoding and a helper that recognises the supported services.
package syscall_unit_pkg;

   localparam logic [31:0] SYS_PRINT_STR  = 32'd4;
   localparam logic [31:0] SYS_EXIT       = 32'd10;
   localparam logic [31:0] SYS_PRINT_CHAR = 32'd11;
   localparam logic [31:0] SYS_PRINT_HEX  = 32'd34;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_STR_REQ,
      ST_STR_WAIT,
      ST_STR_EMIT,
      ST_CHAR_EMIT,
      ST_HEX_EMIT,
      ST_DONE,
      ST_HALTED
   } state_t;

   // True for the service codes the unit acts on; anything else is a no-op.
   function automatic logic is_service(input logic [31:0] code);
      return (code == SYS_PRINT_STR) || (code == SYS_EXIT) ||
             (code == SYS_PRINT_CHAR) || (code == SYS_PRINT_HEX);
   endfunction

endpackage

// File: rtl/syscall_unit_hex_ascii.sv
// Nibble to uppercase ASCII hex digit ('0'-'9', 'A'-'F'); purely combinational
// so debug/trace logic can reuse it.
module hex_ascii (
   input  logic [3:0] nibble,
   output logic [7:0] ascii
);

   // 0-9 map onto 0x30-0x39, 10-15 onto 0x41-0x46.
   always_comb begin
      ascii = (nibble < 4'd10) ? {4'h3, nibble} : (8'h37 + {4'h0, nibble});
   end

endmodule

// File: rtl/syscall_unit.sv
// SYSCALL service unit: print_string, print_char, print_hex and exit.
// Characters leave on a valid/ready stream; the pipeline is stalled while a
// service runs and a sticky halt is raised by exit.
import syscall_unit_pkg::*;

module syscall_unit #(
   parameter int MAX_STR_LEN = 256,
   parameter bit BIG_ENDIAN  = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        syscall,
   input  logic [31:0] v0,
   input  logic [31:0] a0,
   output logic        stall,
   output logic        halt,
   output logic        mem_rd,
   output logic [31:0] mem_addr,
   input  logic [31:0] mem_rdata,
   output logic [7:0]  char_data,
   output logic        char_valid,
   input  logic        char_ready
);

   localparam int CNT_W = $clog2(MAX_STR_LEN + 1);
   localparam logic [CNT_W-1:0] COUNT_MAX = CNT_W'(MAX_STR_LEN);

   state_t            state;
   logic [31:0]       arg_q;
   logic [31:0]       ptr_q;
   logic [CNT_W-1:0]  count_q;
   logic [2:0]        digit_q;

   logic              trigger;
   logic              handshake;
   logic [31:0]       next_ptr;
   logic [1:0]        lane;
   logic [7:0]        str_byte;
   logic [2:0]        next_digit;
   logic [2:0]        hex_idx;
   logic [31:0]       hex_src;
   logic [3:0]        hex_nibble;
   logic [7:0]        hex_char;

   assign trigger   = (state == ST_IDLE) && syscall && is_service(v0);
   assign handshake = char_valid && char_ready;
   assign next_ptr  = ptr_q + 32'd1;
   assign next_digit = digit_q + 3'd1;

   // Stall the pipeline whenever a service is active, and already in the
   // IDLE cycle that accepts a valid code so the SYSCALL does not slip past.
   assign stall = trigger || ((state != ST_IDLE) && (state != ST_DONE));
   assign halt  = (state == ST_HALTED);

   // Pick the addressed byte out of the returned word; lane 3 is the MSB.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // leaves it unassigned and a latch is never inferred.
      str_byte = 8'h00;
      lane     = BIG_ENDIAN ? ~ptr_q[1:0] : ptr_q[1:0];
      case (lane)
         2'd0: str_byte = mem_rdata[7:0];
         2'd1: str_byte = mem_rdata[15:8];
         2'd2: str_byte = mem_rdata[23:16];
         2'd3: str_byte = mem_rdata[31:24];
      endcase
   end

   // Select the nibble for the digit about to be loaded: the top nibble of
   // a0 at the trigger, otherwise the one after the digit being shown.
   always_comb begin
      hex_src    = (state == ST_IDLE) ? a0 : arg_q;
      hex_idx    = (state == ST_IDLE) ? 3'd0 : next_digit;
      hex_nibble = hex_src[{~hex_idx, 2'b00} +: 4];
   end

   hex_ascii u_hex_ascii (
      .nibble (hex_nibble),
      .ascii  (hex_char)
   );

   // Service FSM with registered memory-request and stream outputs.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values regardless of statement order.
      if (rst) begin
         state      <= ST_IDLE;
         arg_q      <= '0;
         ptr_q      <= '0;
         count_q    <= '0;
         digit_q    <= '0;
         mem_rd     <= 1'b0;
         mem_addr   <= '0;
         char_data  <= '0;
         char_valid <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (trigger) begin
                  arg_q   <= a0;
                  ptr_q   <= a0;
                  count_q <= '0;
                  digit_q <= '0;
                  case (v0)
                     SYS_PRINT_STR: begin
                        mem_rd   <= 1'b1;
                        mem_addr <= {a0[31:2], 2'b00};
                        state    <= ST_STR_REQ;
                     end
                     SYS_PRINT_CHAR: begin
                        char_data  <= a0[7:0];
                        char_valid <= 1'b1;
                        state      <= ST_CHAR_EMIT;
                     end
                     SYS_PRINT_HEX: begin
                        char_data  <= hex_char;
                        char_valid <= 1'b1;
                        state      <= ST_HEX_EMIT;
                     end
                     // trigger only fires for known codes, so this is exit
                     default: state <= ST_HALTED;
                  endcase
               end
            end
            ST_STR_REQ: begin
               mem_rd <= 1'b0;
               state  <= ST_STR_WAIT;
            end
            ST_STR_WAIT: begin
               if ((str_byte == 8'h00) || (count_q == COUNT_MAX)) begin
                  state <= ST_DONE;
               end else begin
                  char_data  <= str_byte;
                  char_valid <= 1'b1;
                  state      <= ST_STR_EMIT;
               end
            end
            ST_STR_EMIT: begin
               if (handshake) begin
                  char_valid <= 1'b0;
                  ptr_q      <= next_ptr;
                  if (count_q != COUNT_MAX) count_q <= count_q + 1'b1;
                  // the word is fetched again for every character
                  mem_rd     <= 1'b1;
                  mem_addr   <= {next_ptr[31:2], 2'b00};
                  state      <= ST_STR_REQ;
               end
            end
            ST_CHAR_EMIT: begin
               if (handshake) begin
                  char_valid <= 1'b0;
                  state      <= ST_DONE;
               end
            end
            ST_HEX_EMIT: begin
               if (handshake) begin
                  if (digit_q == 3'd7) begin
                     char_valid <= 1'b0;
                     state      <= ST_DONE;
                  end else begin
                     digit_q   <= next_digit;
                     char_data <= hex_char;
                  end
               end
            end
            // one stall-free cycle lets the PC move past the SYSCALL
            ST_DONE:   state <= ST_IDLE;
            ST_HALTED: state <= ST_HALTED;
         endcase
      end
   end

endmodule

// File: tb/tb_syscall_unit.sv
// Self-checking bench for syscall_unit: a byte-addressed memory and a
// service-level model predict the character stream, the memory read
// addresses and the stall length of every SYSCALL.
module tb_syscall_unit;

   localparam int MAX_LEN = 4;
   localparam bit BE      = 1'b1;

   typedef logic [7:0]  byte_q_t[$];
   typedef logic [31:0] word_q_t[$];

   logic        clk = 1'b0;
   logic        rst;
   logic        syscall;
   logic [31:0] v0;
   logic [31:0] a0;
   logic        stall;
   logic        halt;
   logic        mem_rd;
   logic [31:0] mem_addr;
   logic [31:0] mem_rdata = 32'h0;
   logic [7:0]  char_data;
   logic        char_valid;
   logic        char_ready;

   syscall_unit #(.MAX_STR_LEN(MAX_LEN), .BIG_ENDIAN(BE)) dut (
      .clk        (clk),
      .rst        (rst),
      .syscall    (syscall),
      .v0         (v0),
      .a0         (a0),
      .stall      (stall),
      .halt       (halt),
      .mem_rd     (mem_rd),
      .mem_addr   (mem_addr),
      .mem_rdata  (mem_rdata),
      .char_data  (char_data),
      .char_valid (char_valid),
      .char_ready (char_ready)
   );

   always #5 clk = ~clk;

   int      tests = 0;
   int      fails = 0;
   logic [7:0] mem_b [0:1023];
   byte_q_t exp_chars;
   word_q_t exp_addrs;
   logic    exp_halt = 1'b0;
   int      waits = 0;
   int      hs_count = 0;
   bit      rand_ready = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name, input logic [31:0] act);
      tests++;
      fails++;
      $display("FAIL %s: got %0h, expected nothing", name, act);
   endtask

   // Memory: a byte array; words are assembled by address order.
   function automatic logic [31:0] word_at(input logic [31:0] addr);
      logic [9:0] b;
      b = {addr[9:2], 2'b00};
      if (BE) return {mem_b[b], mem_b[b + 10'd1], mem_b[b + 10'd2], mem_b[b + 10'd3]};
      return {mem_b[b + 10'd3], mem_b[b + 10'd2], mem_b[b + 10'd1], mem_b[b]};
   endfunction

   always @(posedge clk) if (mem_rd) mem_rdata <= word_at(mem_addr);

   // print_string model: read the byte at ptr+k; stop on null or after MAX_LEN.
   task automatic model_string(input logic [31:0] ptr, output byte_q_t cq, output word_q_t aq);
      logic [31:0] p;
      cq = {};
      aq = {};
      for (int k = 0; k <= MAX_LEN; k++) begin
         p = ptr + 32'(k);
         aq.push_back({p[31:2], 2'b00});
         if (k == MAX_LEN) break;
         if (mem_b[p[9:0]] == 8'h00) break;
         cq.push_back(mem_b[p[9:0]]);
      end
   endtask

   task automatic model_hex(input logic [31:0] arg, output byte_q_t cq);
      int nib;
      cq = {};
      for (int i = 0; i < 8; i++) begin
         nib = int'((arg >> (28 - 4 * i)) & 32'hF);
         cq.push_back((nib < 10) ? 8'(48 + nib) : 8'(55 + nib));
      end
   endtask

   // Randomised sink backpressure when enabled.
   initial forever begin
      @(posedge clk);
      #1;
      if (rand_ready) char_ready = ($urandom_range(0, 3) != 0);
   end

   // Per-cycle compare: stream stability, character order, read addresses, halt.
   initial begin : compare
      logic       prev_wait;
      logic [7:0] prev_data;
      prev_wait = 1'b0;
      prev_data = 8'h00;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_wait = 1'b0;
            continue;
         end
         if (prev_wait) begin
            check("hold_valid", char_valid, 1'b1);
            check("hold_data", char_data, prev_data);
         end
         check("halt", halt, exp_halt);
         if (char_valid && char_ready) begin
            hs_count++;
            if (exp_chars.size() == 0) fail_now("extra_char", char_data);
            else check("char", char_data, exp_chars.pop_front());
         end
         if (char_valid && !char_ready) waits++;
         if (mem_rd) begin
            if (exp_addrs.size() == 0) fail_now("extra_mem_rd", mem_addr);
            else check("mem_addr", mem_addr, exp_addrs.pop_front());
         end
         prev_wait = char_valid && !char_ready;
         prev_data = char_data;
      end
   end

   // Issue one SYSCALL and follow it to the DONE cycle, checking stall length.
   task automatic run_service(input logic [31:0] code, input logic [31:0] arg,
                              input bit hold, output int n_stall);
      byte_q_t cq;
      word_q_t aq;
      int      base;
      bit      done;
      waits    = 0;
      hs_count = 0;
      base     = 0;
      cq       = {};
      aq       = {};
      case (code)
         32'd4: begin
            model_string(arg, cq, aq);
            base = 3 + 3 * cq.size();
         end
         32'd11: begin
            cq.push_back(arg[7:0]);
            base = 2;
         end
         32'd34: begin
            model_hex(arg, cq);
            base = 9;
         end
         default: base = 0;
      endcase
      foreach (cq[i]) exp_chars.push_back(cq[i]);
      foreach (aq[i]) exp_addrs.push_back(aq[i]);
      @(posedge clk);
      #1;
      syscall = 1'b1;
      v0      = code;
      a0      = arg;
      @(negedge clk);
      check("trigger_stall", stall, base != 0);
      n_stall = 0;
      if (base != 0) begin
         n_stall = 1;
         @(posedge clk);
         #1;
         if (!hold) syscall = 1'b0;
         done = 1'b0;
         for (int c = 0; c < 3000 && !done; c++) begin
            @(negedge clk);
            if (stall) n_stall++;
            else done = 1'b1;
         end
         if (!done) fail_now("stall_timeout", n_stall);
         check("stall_cycles", n_stall, base + waits);
         check("chars_left", exp_chars.size(), 0);
         check("reads_left", exp_addrs.size(), 0);
         @(posedge clk);
         #1;
         syscall = 1'b0;
         @(negedge clk);
         check("idle_after_done", stall, 1'b0);
      end else begin
         @(posedge clk);
         #1;
         syscall = 1'b0;
         repeat (3) begin
            @(negedge clk);
            check("noop_stall", stall, 1'b0);
         end
      end
   endtask

   initial begin : stimulus
      int      ns;
      byte_q_t cq;
      word_q_t aq;
      bit      ok;
      logic [31:0] p;
      int      len;

      for (int i = 0; i < 1024; i++) mem_b[i] = 8'h00;
      rst = 1'b1;
      syscall = 1'b0;
      v0 = 32'h0;
      a0 = 32'h0;
      char_ready = 1'b0;
      #1;
      check("rst_stall", stall, 1'b0);
      check("rst_halt", halt, 1'b0);
      check("rst_mem_rd", mem_rd, 1'b0);
      check("rst_mem_addr", mem_addr, 32'h0);
      check("rst_char_valid", char_valid, 1'b0);
      check("rst_char_data", char_data, 8'h00);
      #11;
      rst = 1'b0;

      // "Hi" at 0x100 with the sink always ready
      mem_b[10'h100] = 8'h48;
      mem_b[10'h101] = 8'h69;
      mem_b[10'h102] = 8'h00;
      model_string(32'h100, cq, aq);
      check("pin_str_len", cq.size(), 2);
      check("pin_str_c1", cq[1], 8'h69);
      char_ready = 1'b1;
      run_service(32'd4, 32'h100, 1'b0, ns);
      check("hi_stall", ns, 9);

      // hex with a 5-cycle backpressure gap on the third digit
      model_hex(32'hDEADBEEF, cq);
      check("pin_hex_d2", cq[2], 8'h41);
      check("pin_hex_d7", cq[7], 8'h46);
      fork
         run_service(32'd34, 32'hDEADBEEF, 1'b0, ns);
         begin
            ok = 1'b0;
            for (int c = 0; c < 200 && !ok; c++) begin
               @(negedge clk);
               #1;
               if (hs_count >= 2) ok = 1'b1;
            end
            if (!ok) fail_now("hex_hold_timeout", hs_count);
            @(posedge clk);
            #1;
            char_ready = 1'b0;
            repeat (5) begin
               @(negedge clk);
               check("held_digit", char_data, 8'h41);
            end
            @(posedge clk);
            #1;
            char_ready = 1'b1;
         end
      join
      check("hex_stall", ns, 14);

      // print_char with syscall held through DONE, then a null character
      run_service(32'd11, 32'h0000_0241, 1'b1, ns);
      check("char_stall", ns, 2);
      run_service(32'd11, 32'h0, 1'b0, ns);

      // empty string
      run_service(32'd4, 32'h102, 1'b0, ns);
      check("empty_stall", ns, 3);

      // pointer wraps across 2^32
      mem_b[10'h3FE] = 8'h61;
      mem_b[10'h3FF] = 8'h62;
      mem_b[10'h000] = 8'h63;
      mem_b[10'h001] = 8'h00;
      run_service(32'd4, 32'hFFFF_FFFE, 1'b0, ns);
      check("wrap_stall", ns, 12);

      // unaligned string longer than MAX_LEN
      for (int i = 0; i < 10; i++) mem_b[10'h203 + 10'(i)] = 8'(8'h30 + i);
      model_string(32'h203, cq, aq);
      check("pin_trunc_len", cq.size(), MAX_LEN);
      check("pin_trunc_a0", aq[0], 32'h200);
      check("pin_trunc_a1", aq[1], 32'h204);
      run_service(32'd4, 32'h203, 1'b0, ns);
      check("trunc_stall", ns, 15);

      // unknown service code
      run_service(32'd99, 32'h100, 1'b0, ns);

      // randomised services under random backpressure
      rand_ready = 1'b1;
      for (int it = 0; it < 24; it++) begin
         case ($urandom_range(0, 3))
            0: begin
               p   = 32'($urandom_range(32'h280, 32'h3C0));
               len = int'($urandom_range(0, 6));
               for (int i = 0; i < len; i++) mem_b[p[9:0] + 10'(i)] = 8'($urandom_range(1, 255));
               mem_b[p[9:0] + 10'(len)] = 8'h00;
               run_service(32'd4, p, 1'b0, ns);
            end
            1: run_service(32'd11, $urandom, $urandom_range(0, 1) == 1, ns);
            2: run_service(32'd34, $urandom, 1'b0, ns);
            default: run_service(32'($urandom_range(12, 33)), $urandom, 1'b0, ns);
         endcase
      end
      rand_ready = 1'b0;

      // reset while a character is waiting for the sink
      char_ready = 1'b0;
      model_string(32'h100, cq, aq);
      foreach (cq[i]) exp_chars.push_back(cq[i]);
      foreach (aq[i]) exp_addrs.push_back(aq[i]);
      @(posedge clk);
      #1;
      syscall = 1'b1;
      v0 = 32'd4;
      a0 = 32'h100;
      @(posedge clk);
      #1;
      syscall = 1'b0;
      ok = 1'b0;
      for (int c = 0; c < 20 && !ok; c++) begin
         @(negedge clk);
         if (char_valid) ok = 1'b1;
      end
      if (!ok) fail_now("emit_timeout", char_valid);
      repeat (2) @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("mid_rst_valid", char_valid, 1'b0);
      check("mid_rst_stall", stall, 1'b0);
      check("mid_rst_mem_rd", mem_rd, 1'b0);
      check("mid_rst_data", char_data, 8'h00);
      exp_chars = {};
      exp_addrs = {};
      @(negedge clk);
      #1;
      rst = 1'b0;
      char_ready = 1'b1;
      run_service(32'd11, 32'h4A, 1'b0, ns);
      check("post_rst_char_stall", ns, 2);

      // exit: permanent halt, later syscalls ignored, async reset clears it
      @(posedge clk);
      #1;
      syscall = 1'b1;
      v0 = 32'd10;
      a0 = 32'h0;
      @(negedge clk);
      check("exit_trigger_stall", stall, 1'b1);
      @(posedge clk);
      #1;
      exp_halt = 1'b1;
      syscall = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check("halted_stall", stall, 1'b1);
      end
      @(posedge clk);
      #1;
      syscall = 1'b1;
      v0 = 32'd4;
      a0 = 32'h100;
      repeat (4) begin
         @(negedge clk);
         check("halted_no_rd", mem_rd, 1'b0);
         check("halted_stall2", stall, 1'b1);
      end
      syscall = 1'b0;
      @(posedge clk);
      #3;
      rst = 1'b1;
      exp_halt = 1'b0;
      #1;
      check("rst_clears_halt", halt, 1'b0);
      check("rst_clears_stall", stall, 1'b0);
      #2;
      rst = 1'b0;
      repeat (2) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
